edram_access_scheduler: RTL

- Sits directly upstream of sram_top and is the only driver of its addr/din/ce_n/we_n pins.
- Accepts host read/write requests over a valid/ready handshake and holds each access for a fixed number of cycles so the controller and PMU can wake the bank and complete it.
- Returns read data on a one-cycle response strobe.
- Schedules periodic refresh accesses to every row of the implemented banks. A refresh is a dummy read that produces no host response. Refreshes may be postponed behind host traffic up to a threshold.

---
 rtl/edram_access_scheduler_pkg.sv | 28 ++
 rtl/edram_access_scheduler_if.sv | 23 ++
 rtl/edram_access_scheduler_refresh_credit_ctr.sv | 49 ++++
 rtl/edram_access_scheduler.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/edram_access_scheduler_pkg.sv
// Shared widths, address field layout and scheduler state encoding for the eDRAM access scheduler.
package edram_pkg;

    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BANK_W   = 4;
    localparam int unsigned ROW_W    = 6;
    localparam int unsigned COL_W    = 5;
    localparam int unsigned BANK_LSB = 11;
    localparam int unsigned ROW_LSB  = 5;

    // Access cycle counter and pending-refresh counter both top out at 15.
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PEND_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        HOST_ACC,
        REF_ACC
    } sched_state_t;

    // Refresh accesses always target column 0 of the selected row.
    function automatic logic [ADDR_W-1:0] ref_addr(input logic [BANK_W-1:0] bank,
                                                   input logic [ROW_W-1:0]  row);
        return {bank, row, {COL_W{1'b0}}};
    endfunction

endpackage

// File: rtl/edram_access_scheduler_if.sv
// Host request/response channel between a requester and the eDRAM access scheduler.
interface edram_access_scheduler_if;
    import edram_pkg::*;

    logic              host_valid;
    logic              host_ready;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output host_valid, host_we, host_addr, host_wdata,
        input  host_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  host_valid, host_we, host_addr, host_wdata,
        output host_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/edram_access_scheduler_refresh_credit_ctr.sv
// Interval timer that issues refresh credits into a saturating pending counter with sticky overflow.
module refresh_credit_ctr
    import edram_pkg::*;
#(
    parameter int unsigned REFRESH_INTERVAL = 512,
    parameter int unsigned MAX_PEND         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec,
    output logic [PEND_W-1:0] pend,
    output logic              overflow
);

    localparam int unsigned TMR_W = $clog2(REFRESH_INTERVAL);

    logic [TMR_W-1:0] tmr;
    logic             credit;

    assign credit = (tmr == TMR_W'(REFRESH_INTERVAL - 1));

    // Free-running interval timer; runs regardless of scheduler state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr <= '0;
        end else if (credit) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + TMR_W'(1);
        end
    end

    // Pending count: credit and decrement on the same edge cancel; a credit at saturation is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            overflow <= 1'b0;
        end else if (credit && !dec) begin
            if (pend == PEND_W'(MAX_PEND)) begin
                overflow <= 1'b1;
            end else begin
                pend <= pend + PEND_W'(1);
            end
        end else if (dec && !credit) begin
            pend <= pend - PEND_W'(1);
        end
    end

endmodule

// File: rtl/edram_access_scheduler.sv
// Serialises host accesses and periodic row refreshes onto the sram_top pins, holding each access for a fixed window.
module edram_access_scheduler
    import edram_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES    = 4,
    parameter int unsigned REFRESH_INTERVAL = 512,
    parameter int unsigned URGENT_THRESH    = 4,
    parameter int unsigned MAX_PEND         = 8,
    parameter int unsigned NUM_BANKS        = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    edram_access_scheduler_if.slave   host,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_din,
    output logic                      mem_ce_n,
    output logic                      mem_we_n,
    input  logic [DATA_W-1:0]         mem_dout,
    output logic                      busy,
    output logic                      ref_overflow
);

    sched_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_din_d;
    logic              mem_ce_n_d;
    logic              mem_we_n_d;
    logic              busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [PEND_W-1:0] pend;
    logic              ref_dec;
    logic              urgent;

    refresh_credit_ctr #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL),
        .MAX_PEND         (MAX_PEND)
    ) u_credit (
        .clk      (clk),
        .rst_n    (rst_n),
        .dec      (ref_dec),
        .pend     (pend),
        .overflow (ref_overflow)
    );

    assign urgent          = (pend >= PEND_W'(URGENT_THRESH));
    assign host.host_ready = (state_q == IDLE) && !urgent;
    assign host.rsp_valid  = rsp_valid_q;
    assign host.rsp_data   = rsp_data_q;

    // Next-state, access window and pin values; refresh wins when urgent, host next, then idle refresh.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bank_d      = bank_q;
        row_d       = row_q;
        mem_addr_d  = mem_addr;
        mem_din_d   = mem_din;
        mem_ce_n_d  = mem_ce_n;
        mem_we_n_d  = mem_we_n;
        busy_d      = busy;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        ref_dec     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (urgent || (!host.host_valid && (pend != '0))) begin
                    state_d    = REF_ACC;
                    cnt_d      = '0;
                    mem_addr_d = ref_addr(bank_q, row_q);
                    mem_we_n_d = 1'b1;
                    mem_ce_n_d = 1'b0;
                    busy_d     = 1'b1;
                    ref_dec    = 1'b1;
                    row_d      = row_q + ROW_W'(1);
                    if (&row_q) begin
                        bank_d = (bank_q == BANK_W'(NUM_BANKS - 1)) ? '0 : bank_q + BANK_W'(1);
                    end
                end else if (host.host_valid) begin
                    state_d    = HOST_ACC;
                    cnt_d      = '0;
                    mem_addr_d = host.host_addr;
                    mem_din_d  = host.host_wdata;
                    mem_we_n_d = ~host.host_we;
                    mem_ce_n_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            HOST_ACC, REF_ACC: begin
                if (cnt_q == CNT_W'(ACCESS_CYCLES - 1)) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    mem_ce_n_d = 1'b1;
                    busy_d     = 1'b0;
                    if ((state_q == HOST_ACC) && mem_we_n) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = mem_dout;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, refresh pointer and registered pin/response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bank_q      <= '0;
            row_q       <= '0;
            mem_addr    <= '0;
            mem_din     <= '0;
            mem_ce_n    <= 1'b1;
            mem_we_n    <= 1'b1;
            busy        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bank_q      <= bank_d;
            row_q       <= row_d;
            mem_addr    <= mem_addr_d;
            mem_din     <= mem_din_d;
            mem_ce_n    <= mem_ce_n_d;
            mem_we_n    <= mem_we_n_d;
            busy        <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule
